pwm_generator: RTL and testbench



---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_deadtime.sv | 54 +++++
 rtl/pwm_generator.sv | 154 +++++++++++++++
 tb/tb_pwm_generator.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM generator slice.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } pwm_state_e;

  localparam int CNT_W_DEF = 8;
  localparam int DT_W_DEF  = 4;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time insertion: delays each rising edge of pwm_out/pwm_n by dt ticks.
// Fed with next-cycle values so both outputs stay registered and aligned with the counter.
module pwm_deadtime #(
  parameter int DT_W = 4
) (
  input  logic            clk,
  input  logic            rst_a,
  input  logic            tick_en,
  input  logic            run_nxt,
  input  logic            cmp_nxt,
  input  logic [DT_W-1:0] dt_nxt,
  output logic            pwm_out,
  output logic            pwm_n
);

  logic            run_q;
  logic            cmp_q;
  logic [DT_W-1:0] ph_q;
  logic [DT_W-1:0] ph_nxt;
  logic            gap_done;

  function automatic logic [DT_W-1:0] sat_inc(input logic [DT_W-1:0] v);
    return (v == '1) ? v : v + DT_W'(1);
  endfunction

  // ph counts ticks elapsed in the current compare phase; a fresh phase starts on
  // every compare edge and on entry to RUN.
  always_comb begin
    ph_nxt = ph_q;
    if ((cmp_nxt != cmp_q) || (run_nxt && !run_q))
      ph_nxt = '0;
    else if (tick_en && run_q)
      ph_nxt = sat_inc(ph_q);
  end

  assign gap_done = (ph_nxt >= dt_nxt);

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      run_q   <= 1'b0;
      cmp_q   <= 1'b0;
      ph_q    <= '0;
      pwm_out <= 1'b0;
      pwm_n   <= 1'b0;
    end else begin
      run_q   <= run_nxt;
      cmp_q   <= cmp_nxt;
      ph_q    <= ph_nxt;
      pwm_out <= run_nxt && cmp_nxt && gap_done;
      pwm_n   <= run_nxt && !cmp_nxt && gap_done;
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// Tick-driven PWM with double-buffered period/duty applied only at period boundaries.
// Optional dead-time / complementary output when PWM_DEADTIME_EN is defined.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
`ifdef PWM_DEADTIME_EN
  ,
  parameter int DT_W  = DT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             tick_en,
  input  logic             enable,
  input  logic [CNT_W-1:0] period_in,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             load,
  output logic             load_ack,
  output logic             period_end,
  output logic             busy,
  output logic             pwm_out
`ifdef PWM_DEADTIME_EN
  ,
  input  logic [DT_W-1:0]  dt_in,
  output logic             pwm_n
`endif
);

  pwm_state_e       state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] period_act, period_nxt, period_pend;
  logic [CNT_W-1:0] duty_act, duty_nxt, duty_pend;
  logic             pend;
  logic             apply;
  logic             wrap;
  logic             run_nxt;
  logic             cmp_nxt;

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    period_nxt = period_act;
    duty_nxt   = duty_act;
    apply      = 1'b0;
    wrap       = 1'b0;

    case (state)
      IDLE: begin
        apply     = pend;
        count_nxt = '0;
      end
      RUN, STOP: begin
        if (tick_en) begin
          if (count == period_act - CNT_W'(1)) begin
            wrap      = 1'b1;
            apply     = pend;
            count_nxt = '0;
          end else begin
            count_nxt = count + CNT_W'(1);
          end
        end
      end
      default: count_nxt = '0;
    endcase

    if (apply) begin
      period_nxt = period_pend;
      duty_nxt   = duty_pend;
    end

    // Run decisions use the post-boundary period so a zero period never starts or continues.
    case (state)
      IDLE: if (enable && (period_nxt != '0)) state_nxt = RUN;
      RUN: begin
        if (wrap && (period_nxt == '0)) state_nxt = IDLE;
        else if (!enable)               state_nxt = STOP;
      end
      STOP: begin
        if (wrap && (period_nxt == '0)) state_nxt = IDLE;
        else if (enable)                state_nxt = RUN;
        else if (wrap)                  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    run_nxt = (state_nxt != IDLE);
    cmp_nxt = run_nxt && (count_nxt < duty_nxt);
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state       <= IDLE;
      count       <= '0;
      period_act  <= '0;
      duty_act    <= '0;
      period_pend <= '0;
      duty_pend   <= '0;
      pend        <= 1'b0;
      load_ack    <= 1'b0;
      period_end  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      period_act <= period_nxt;
      duty_act   <= duty_nxt;
      load_ack   <= apply;
      period_end <= wrap;
      busy       <= run_nxt;
      // A load coinciding with a boundary stays pending for the next one.
      if (load) begin
        pend        <= 1'b1;
        period_pend <= period_in;
        duty_pend   <= duty_in;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

`ifdef PWM_DEADTIME_EN
  logic [DT_W-1:0] dt_pend, dt_act, dt_nxt;

  assign dt_nxt = apply ? dt_pend : dt_act;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      dt_pend <= '0;
      dt_act  <= '0;
    end else begin
      dt_act <= dt_nxt;
      if (load) dt_pend <= dt_in;
    end
  end

  pwm_deadtime #(.DT_W(DT_W)) u_deadtime (
    .clk     (clk),
    .rst_a   (rst_a),
    .tick_en (tick_en),
    .run_nxt (run_nxt),
    .cmp_nxt (cmp_nxt),
    .dt_nxt  (dt_nxt),
    .pwm_out (pwm_out),
    .pwm_n   (pwm_n)
  );
`else
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) pwm_out <= 1'b0;
    else        pwm_out <= cmp_nxt;
  end
`endif

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator; covers dead-time when PWM_DEADTIME_EN is defined.
module tb_pwm_generator;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       tick_en = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [7:0] period_in = '0;
  logic [7:0] duty_in = '0;
  logic       load_ack, period_end, busy, pwm_out;
`ifdef PWM_DEADTIME_EN
  logic [3:0] dt_in = '0;
  logic       pwm_n;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pwm_generator dut (
    .clk        (clk),
    .rst_a      (rst_a),
    .tick_en    (tick_en),
    .enable     (enable),
    .period_in  (period_in),
    .duty_in    (duty_in),
    .load       (load),
    .load_ack   (load_ack),
    .period_end (period_end),
    .busy       (busy),
    .pwm_out    (pwm_out)
`ifdef PWM_DEADTIME_EN
    ,
    .dt_in      (dt_in),
    .pwm_n      (pwm_n)
`endif
  );

  // got/exp vectors are {pwm_out, period_end, load_ack, busy}
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_a   = 1'b0;
    load    = 1'b0;
    enable  = 1'b0;
    tick_en = 1'b0;
    step();
    step();
    rst_a = 1'b1;
  endtask

  // Leaves the DUT in RUN at count 0 (sample k=0), ticking every clk.
  task automatic start_run(input logic [7:0] p, input logic [7:0] d);
    do_reset();
    period_in = p;
    duty_in   = d;
    load      = 1'b1;
    step();
    load    = 1'b0;
    enable  = 1'b1;
    tick_en = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst_a = 1'b0;
    #12;
    got = {pwm_out, period_end, load_ack, busy};
    n_total++;
    if (got !== 4'b0000) $display("FAIL reset_outputs got %b exp 0000", got);
    else n_pass++;
`ifdef PWM_DEADTIME_EN
    n_total++;
    if (pwm_n !== 1'b0) $display("FAIL reset_pwm_n got %b exp 0", pwm_n);
    else n_pass++;
`endif
    rst_a = 1'b1;
    period_in = 8'd10;
    duty_in   = 8'd3;
    load      = 1'b1;
    step();
    load = 1'b0;
    got = {pwm_out, period_end, load_ack, busy};
    n_total++;
    if (got !== 4'b0000) $display("FAIL load_only_pending got %b exp 0000", got);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [3:0] got, exp;
    start_run(8'd10, 8'd3);
    got = {pwm_out, period_end, load_ack, busy};
    n_total++;
    if (got !== 4'b1011) $display("FAIL basic_entry got %b exp 1011", got);
    else n_pass++;
    for (int k = 1; k <= 24; k++) begin
      step();
      got = {pwm_out, period_end, load_ack, busy};
      exp = {(k % 10) < 3, (k % 10) == 0, 1'b0, 1'b1};
      n_total++;
      if (got !== exp) $display("FAIL basic k=%0d got %b exp %b", k, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_slow_tick();
    logic [3:0] got, exp;
    do_reset();
    period_in = 8'd5;
    duty_in   = 8'd2;
    load      = 1'b1;
    step();
    load   = 1'b0;
    enable = 1'b1;
    step();
    got = {pwm_out, period_end, load_ack, busy};
    n_total++;
    if (got !== 4'b1011) $display("FAIL slow_entry got %b exp 1011", got);
    else n_pass++;
    for (int c = 1; c <= 40; c++) begin
      tick_en = ((c - 1) % 4) == 3;
      step();
      got = {pwm_out, period_end, load_ack, busy};
      exp = {((c / 4) % 5) < 2, (c % 20) == 0, 1'b0, 1'b1};
      n_total++;
      if (got !== exp) $display("FAIL slow_tick c=%0d got %b exp %b", c, got, exp);
      else n_pass++;
    end
    tick_en = 1'b0;
  endtask

  task automatic test_reload();
    logic [3:0] got, exp;
    start_run(8'd10, 8'd3);
    for (int k = 1; k <= 24; k++) begin
      load      = (k == 5);
      period_in = 8'd10;
      duty_in   = 8'd7;
      step();
      got = {pwm_out, period_end, load_ack, busy};
      exp = {(k < 10) ? ((k % 10) < 3) : ((k % 10) < 7), (k % 10) == 0, k == 10, 1'b1};
      n_total++;
      if (got !== exp) $display("FAIL reload k=%0d got %b exp %b", k, got, exp);
      else n_pass++;
    end
    load = 1'b0;
  endtask

  task automatic test_duty_extremes();
    logic [3:0] got, exp;
    start_run(8'd10, 8'd0);
    got = {pwm_out, period_end, load_ack, busy};
    n_total++;
    if (got !== 4'b0011) $display("FAIL duty0_entry got %b exp 0011", got);
    else n_pass++;
    for (int k = 1; k <= 39; k++) begin
      load      = (k == 13);
      period_in = 8'd10;
      duty_in   = 8'd12;
      step();
      got = {pwm_out, period_end, load_ack, busy};
      exp = {k >= 20, (k % 10) == 0, k == 20, 1'b1};
      n_total++;
      if (got !== exp) $display("FAIL duty_extremes k=%0d got %b exp %b", k, got, exp);
      else n_pass++;
    end
    load = 1'b0;
  endtask

  task automatic test_simul_load();
    logic [3:0] got, exp;
    logic       pw;
    start_run(8'd10, 8'd3);
    for (int k = 1; k <= 34; k++) begin
      load      = (k == 5) || (k == 10);
      period_in = 8'd10;
      duty_in   = (k == 5) ? 8'd5 : 8'd8;
      step();
      if (k < 10)      pw = (k % 10) < 3;
      else if (k < 20) pw = (k % 10) < 5;
      else             pw = (k % 10) < 8;
      got = {pwm_out, period_end, load_ack, busy};
      exp = {pw, (k % 10) == 0, (k == 10) || (k == 20), 1'b1};
      n_total++;
      if (got !== exp) $display("FAIL simul_load k=%0d got %b exp %b", k, got, exp);
      else n_pass++;
    end
    load = 1'b0;
  endtask

  task automatic test_stop();
    logic [3:0] got, exp;
    start_run(8'd10, 8'd6);
    for (int k = 1; k <= 14; k++) begin
      enable = (k < 5);
      step();
      got = {pwm_out, period_end, load_ack, busy};
      if (k < 10)       exp = {(k % 10) < 6, 1'b0, 1'b0, 1'b1};
      else if (k == 10) exp = 4'b0100;
      else              exp = 4'b0000;
      n_total++;
      if (got !== exp) $display("FAIL stop k=%0d got %b exp %b", k, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_stop_resume();
    logic [3:0] got, exp;
    start_run(8'd10, 8'd6);
    for (int k = 1; k <= 24; k++) begin
      enable = !((k >= 5) && (k <= 6));
      step();
      got = {pwm_out, period_end, load_ack, busy};
      exp = {(k % 10) < 6, (k % 10) == 0, 1'b0, 1'b1};
      n_total++;
      if (got !== exp) $display("FAIL stop_resume k=%0d got %b exp %b", k, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] got;
    start_run(8'd10, 8'd3);
    step();
    step();
    got = {pwm_out, period_end, load_ack, busy};
    n_total++;
    if (got !== 4'b1001) $display("FAIL pre_async_reset got %b exp 1001", got);
    else n_pass++;
    #2;
    rst_a = 1'b0;
    #1;
    got = {pwm_out, period_end, load_ack, busy};
    n_total++;
    if (got !== 4'b0000) $display("FAIL async_reset got %b exp 0000", got);
    else n_pass++;
    step();
    rst_a = 1'b1;
  endtask

`ifdef PWM_DEADTIME_EN
  task automatic test_deadtime();
    logic [1:0] got, exp;
    do_reset();
    period_in = 8'd10;
    duty_in   = 8'd5;
    dt_in     = 4'd2;
    load      = 1'b1;
    step();
    load    = 1'b0;
    dt_in   = 4'd0;
    enable  = 1'b1;
    tick_en = 1'b1;
    step();
    for (int k = 0; k <= 24; k++) begin
      got = {pwm_out, pwm_n};
      exp = {((k % 10) >= 2) && ((k % 10) <= 4), (k % 10) >= 7};
      n_total++;
      if (got !== exp) $display("FAIL deadtime k=%0d got %b exp %b", k, got, exp);
      else n_pass++;
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_slow_tick();
    test_reload();
    test_duty_extremes();
    test_simul_load();
    test_stop();
    test_stop_resume();
    test_async_reset();
`ifdef PWM_DEADTIME_EN
    test_deadtime();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
